// File: rtl/exc_pkg.sv
// Shared constants for the writeback exception controller: wb_exc bit indices,
// ecode/esubcode values, FSM state encoding and the instruction classification kinds.
package exc_pkg;

    localparam int EXC_ADEF = 0;
    localparam int EXC_INE  = 1;
    localparam int EXC_SYS  = 2;
    localparam int EXC_BRK  = 3;
    localparam int EXC_ALE  = 4;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    localparam logic [8:0] ESUBCODE_NONE = 9'd0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_FLUSH    = 2'd2,
        S_REDIRECT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_NORMAL = 2'd0,
        K_EXC    = 2'd1,
        K_ERTN   = 2'd2
    } kind_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority classification of a writeback instruction:
// INT > ADEF > INE > SYS > BRK > ALE > ERTN > normal.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       int_req,
    input  logic [4:0] exc,
    input  logic       ertn,
    output kind_t      kind,
    output logic [5:0] ecode,
    output logic [8:0] esubcode,
    output logic       vaddr_is_pc
);

    always_comb begin
        kind        = K_NORMAL;
        ecode       = 6'h00;
        esubcode    = ESUBCODE_NONE;
        vaddr_is_pc = 1'b0;
        if (int_req) begin
            kind  = K_EXC;
            ecode = ECODE_INT;
        end else if (exc[EXC_ADEF]) begin
            // Fetch-side fault: the faulting address is the PC itself
            kind        = K_EXC;
            ecode       = ECODE_ADEF;
            vaddr_is_pc = 1'b1;
        end else if (exc[EXC_INE]) begin
            kind  = K_EXC;
            ecode = ECODE_INE;
        end else if (exc[EXC_SYS]) begin
            kind  = K_EXC;
            ecode = ECODE_SYS;
        end else if (exc[EXC_BRK]) begin
            kind  = K_EXC;
            ecode = ECODE_BRK;
        end else if (exc[EXC_ALE]) begin
            kind  = K_EXC;
            ecode = ECODE_ALE;
        end else if (ertn) begin
            kind = K_ERTN;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Writeback exception/ERTN controller: commits, flushes and redirects fetch.
// Build macro EXC_CTRL_INT_EN enables taking interrupts from has_int.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | accepting writeback instructions, normal ones retire here
// S_COMMIT   | one cycle: pulse csr_wb_ex / csr_ertn_flush, record valid
// S_FLUSH    | flush held for FLUSH_CYCLES cycles (down-counter)
// S_REDIRECT | flush + redirect_valid until redirect_ready
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid,
    output logic        wb_accept,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic [4:0]  wb_exc,
    input  logic        wb_ertn,
    input  logic        has_int,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        wb_commit,
    output logic        csr_wb_ex,
    output logic        csr_ertn_flush,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_pc,
    output logic [31:0] csr_vaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);

`ifdef EXC_CTRL_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    state_t     state;
    logic [3:0] flush_cnt;
    logic       redirect_ertn;

    kind_t      kind;
    logic [5:0] ecode;
    logic [8:0] esubcode;
    logic       vaddr_is_pc;
    logic       take;

    exc_prio_enc u_prio (
        .int_req     (has_int & INT_EN),
        .exc         (wb_exc),
        .ertn        (wb_ertn),
        .kind        (kind),
        .ecode       (ecode),
        .esubcode    (esubcode),
        .vaddr_is_pc (vaddr_is_pc)
    );

    assign wb_accept = (state == S_IDLE) & ~reset;
    assign take      = wb_valid & wb_accept;
    assign wb_commit = take & (kind == K_NORMAL);

    // Redirect target follows the CSR inputs live while redirect_valid is up
    assign redirect_pc = redirect_valid ? (redirect_ertn ? csr_era : csr_eentry) : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            flush_cnt      <= 4'd0;
            redirect_ertn  <= 1'b0;
            csr_wb_ex      <= 1'b0;
            csr_ertn_flush <= 1'b0;
            csr_ecode      <= 6'h00;
            csr_esubcode   <= 9'h000;
            csr_pc         <= 32'h0;
            csr_vaddr      <= 32'h0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take && kind != K_NORMAL) begin
                        state          <= S_COMMIT;
                        redirect_ertn  <= (kind == K_ERTN);
                        csr_wb_ex      <= (kind == K_EXC);
                        csr_ertn_flush <= (kind == K_ERTN);
                        csr_ecode      <= ecode;
                        csr_esubcode   <= esubcode;
                        csr_pc         <= wb_pc;
                        csr_vaddr      <= vaddr_is_pc ? wb_pc : wb_vaddr;
                        flush          <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    csr_wb_ex      <= 1'b0;
                    csr_ertn_flush <= 1'b0;
                    flush_cnt      <= 4'(FLUSH_CYCLES);
                    state          <= S_FLUSH;
                end
                S_FLUSH: begin
                    if (flush_cnt == 4'd1) begin
                        state          <= S_REDIRECT;
                        redirect_valid <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        state          <= S_IDLE;
                        flush          <= 1'b0;
                        redirect_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed, table-driven bench for exc_ctrl; expectations follow EXC_CTRL_INT_EN when defined.
module tb_exc_ctrl;

`ifdef EXC_CTRL_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif
    localparam int FLUSH_CYCLES = 2;
    localparam logic [31:0] EENTRY = 32'h1c008000;
    localparam logic [31:0] ERA    = 32'h1c000200;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic        wb_accept;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic [4:0]  wb_exc;
    logic        wb_ertn;
    logic        has_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        wb_commit;
    logic        csr_wb_ex;
    logic        csr_ertn_flush;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_pc;
    logic [31:0] csr_vaddr;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    int errors = 0;
    int checks = 0;

    exc_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_accept      (wb_accept),
        .wb_pc          (wb_pc),
        .wb_vaddr       (wb_vaddr),
        .wb_exc         (wb_exc),
        .wb_ertn        (wb_ertn),
        .has_int        (has_int),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
        .wb_commit      (wb_commit),
        .csr_wb_ex      (csr_wb_ex),
        .csr_ertn_flush (csr_ertn_flush),
        .csr_ecode      (csr_ecode),
        .csr_esubcode   (csr_esubcode),
        .csr_pc         (csr_pc),
        .csr_vaddr      (csr_vaddr),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  exc;
        logic        ertn;
        logic        intr;
        logic [31:0] pc;
        logic [31:0] vaddr;
        logic        commit;
        logic        wb_ex;
        logic        ertn_fl;
        logic [5:0]  ecode;
        logic [31:0] exp_vaddr;
        logic [31:0] exp_redir;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [4:0] exc, input logic ertn,
                                input logic intr, input logic [31:0] pc, input logic [31:0] vaddr,
                                input logic commit, input logic wb_ex, input logic ertn_fl,
                                input logic [5:0] ecode, input logic [31:0] exp_vaddr,
                                input logic [31:0] exp_redir);
        vec_t v;
        v.name = name; v.exc = exc; v.ertn = ertn; v.intr = intr; v.pc = pc; v.vaddr = vaddr;
        v.commit = commit; v.wb_ex = wb_ex; v.ertn_fl = ertn_fl; v.ecode = ecode;
        v.exp_vaddr = exp_vaddr; v.exp_redir = exp_redir;
        return v;
    endfunction

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_exc = 5'b0; wb_ertn = 1'b0; has_int = 1'b0;
        wb_pc = 32'h0; wb_vaddr = 32'h0;
    endtask

    // Offers one instruction, follows it through COMMIT/FLUSH/REDIRECT, holding
    // redirect_ready low for 'stall' cycles with a spurious wb_valid offered meanwhile.
    task automatic run_vec(input vec_t v, input int stall);
        int n;
        logic [31:0] rpc;
        @(negedge clk);
        wb_valid = 1'b1; wb_exc = v.exc; wb_ertn = v.ertn; has_int = v.intr;
        wb_pc = v.pc; wb_vaddr = v.vaddr;
        #1;
        check({v.name, ".accept"}, 32'(wb_accept), 32'd1);
        check({v.name, ".commit"}, 32'(wb_commit), 32'(v.commit));
        @(negedge clk);
        idle_inputs();
        if (v.commit) begin
            check({v.name, ".idle_flush"}, 32'(flush), 32'd0);
            check({v.name, ".idle_accept"}, 32'(wb_accept), 32'd1);
            return;
        end
        check({v.name, ".wb_ex"}, 32'(csr_wb_ex), 32'(v.wb_ex));
        check({v.name, ".ertn_flush"}, 32'(csr_ertn_flush), 32'(v.ertn_fl));
        check({v.name, ".commit_flush"}, 32'(flush), 32'd1);
        if (v.wb_ex) begin
            check({v.name, ".ecode"}, 32'(csr_ecode), 32'(v.ecode));
            check({v.name, ".esubcode"}, 32'(csr_esubcode), 32'd0);
            check({v.name, ".csr_pc"}, csr_pc, v.pc);
            check({v.name, ".csr_vaddr"}, csr_vaddr, v.exp_vaddr);
        end
        n = 0;
        @(negedge clk);
        while (flush && !redirect_valid && n < 20) begin
            check({v.name, ".flush_no_pulse"}, 32'(csr_wb_ex | csr_ertn_flush), 32'd0);
            n++;
            @(negedge clk);
        end
        check({v.name, ".flush_cycles"}, 32'(n), 32'(FLUSH_CYCLES));
        check({v.name, ".redir_valid"}, 32'(redirect_valid), 32'd1);
        check({v.name, ".redir_flush"}, 32'(flush), 32'd1);
        check({v.name, ".redir_pc"}, redirect_pc, v.exp_redir);
        check({v.name, ".redir_accept"}, 32'(wb_accept), 32'd0);
        rpc = redirect_pc;
        for (int i = 0; i < stall; i++) begin
            wb_valid = 1'b1; wb_pc = 32'h1c0000f0; wb_exc = 5'b0;
            #1;
            check({v.name, ".stall_commit"}, 32'(wb_commit), 32'd0);
            @(negedge clk);
            check({v.name, ".stall_valid"}, 32'(redirect_valid), 32'd1);
            check({v.name, ".stall_pc"}, redirect_pc, rpc);
            check({v.name, ".stall_accept"}, 32'(wb_accept), 32'd0);
            check({v.name, ".stall_wb_ex"}, 32'(csr_wb_ex), 32'd0);
        end
        idle_inputs();
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        check({v.name, ".done_accept"}, 32'(wb_accept), 32'd1);
        check({v.name, ".done_flush"}, 32'(flush), 32'd0);
        check({v.name, ".done_valid"}, 32'(redirect_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = mk("normal", 5'b00000, 0, 0, 32'h1c000000, 32'h0, 1, 0, 0, 6'h00, 32'h0, 32'h0);
        vecs[1] = mk("sys", 5'b00100, 0, 0, 32'h1c000100, 32'h1234, 0, 1, 0, 6'h0B, 32'h1234, EENTRY);
        vecs[2] = mk("adef_ale", 5'b10001, 0, 0, 32'h1c000104, 32'h5, 0, 1, 0, 6'h08, 32'h1c000104, EENTRY);
        vecs[3] = mk("ertn", 5'b00000, 1, 0, 32'h1c000108, 32'h0, 0, 0, 1, 6'h00, 32'h0, ERA);
        vecs[4] = mk("ertn_ine", 5'b00010, 1, 0, 32'h1c00010c, 32'h77, 0, 1, 0, 6'h0D, 32'h77, EENTRY);
        vecs[5] = mk("int_ine", 5'b00010, 0, 1, 32'h1c000110, 32'h9, 0, 1, 0,
                     INT_EN ? 6'h00 : 6'h0D, 32'h9, EENTRY);
        vecs[6] = mk("brk", 5'b01000, 0, 0, 32'h1c000114, 32'h0, 0, 1, 0, 6'h0C, 32'h0, EENTRY);
        vecs[7] = mk("ale", 5'b10000, 0, 0, 32'h1c000118, 32'hdeadbeef, 0, 1, 0, 6'h09, 32'hdeadbeef, EENTRY);
        vecs[8] = mk("ine_sys_brk", 5'b01110, 0, 0, 32'h1c00011c, 32'h40, 0, 1, 0, 6'h0D, 32'h40, EENTRY);
        vecs[9] = mk("int_only", 5'b00000, 0, 1, 32'h1c000120, 32'h0, INT_EN ? 1'b0 : 1'b1,
                     INT_EN, 0, 6'h00, 32'h0, EENTRY);

        idle_inputs();
        redirect_ready = 1'b0;
        csr_eentry = EENTRY;
        csr_era = ERA;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset.accept", 32'(wb_accept), 32'd0);
        check("reset.flush", 32'(flush), 32'd0);
        check("reset.redir", 32'(redirect_valid), 32'd0);
        check("reset.ecode", 32'(csr_ecode), 32'd0);
        check("reset.csr_pc", csr_pc, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("reset.accept_after", 32'(wb_accept), 32'd1);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], 0);

        // Redirect held off for five cycles with an instruction offered meanwhile
        run_vec(vecs[1], 5);

        // Interrupt without an offered instruction is not an event
        @(negedge clk);
        has_int = 1'b1;
        #1;
        check("int_novalid.commit", 32'(wb_commit), 32'd0);
        @(negedge clk);
        has_int = 1'b0;
        check("int_novalid.flush", 32'(flush), 32'd0);
        check("int_novalid.wb_ex", 32'(csr_wb_ex), 32'd0);
        check("int_novalid.accept", 32'(wb_accept), 32'd1);

        // Reset in the middle of FLUSH abandons the sequence
        @(negedge clk);
        wb_valid = 1'b1; wb_exc = 5'b00100; wb_pc = 32'h1c000100;
        @(negedge clk);
        idle_inputs();
        check("rst_mid.commit_wb_ex", 32'(csr_wb_ex), 32'd1);
        @(negedge clk);
        check("rst_mid.in_flush", 32'(flush), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid.flush", 32'(flush), 32'd0);
        check("rst_mid.redir", 32'(redirect_valid), 32'd0);
        check("rst_mid.ecode", 32'(csr_ecode), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid.accept", 32'(wb_accept), 32'd1);
        check("rst_mid.flush_after", 32'(flush), 32'd0);
        repeat (4) @(negedge clk);
        check("rst_mid.redir_after", 32'(redirect_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles spent in FLUSH (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset; reset is synchronous, active-high.
REQ-004 SHALL have port wb_valid, input, 1, a writeback-stage instruction is offered.
REQ-005 SHALL have port wb_accept, output, 1, the instruction is taken this cycle when wb_valid&wb_accept.
REQ-006 SHALL have port wb_pc, input, 32, PC of the offered instruction.
REQ-007 SHALL have port wb_vaddr, input, 32, faulting data address.
REQ-008 SHALL have port wb_exc, input, 5, exception flags: [0]ADEF [1]INE [2]SYS [3]BRK [4]ALE.
REQ-009 SHALL have port wb_ertn, input, 1, the offered instruction is ERTN.
REQ-010 SHALL have port has_int, input, 1, interrupt pending from the CSR file.
REQ-011 SHALL have ports csr_eentry and csr_era, input, 32 each, current EENTRY and ERA values.
REQ-012 SHALL have port wb_commit, output, 1, one-cycle pulse when an accepted instruction retires normally.
REQ-013 SHALL have ports csr_wb_ex and csr_ertn_flush, output, 1 each, one-cycle pulses to the CSR file.
REQ-014 SHALL have ports csr_ecode (6), csr_esubcode (9), csr_pc (32), csr_vaddr (32), output, the exception record.
REQ-015 SHALL have port flush, output, 1, pipeline flush request.
REQ-016 SHALL have ports redirect_valid (output, 1), redirect_pc (output, 32) and redirect_ready (input, 1), a fetch redirect handshake.

Function
REQ-017 SHALL implement the states IDLE, COMMIT, FLUSH and REDIRECT.
REQ-018 SHALL drive wb_accept=1 only in IDLE.
REQ-019 SHALL classify an accepted instruction with this priority: INT (has_int) > ADEF > INE > SYS > BRK > ALE > ERTN > normal.
REQ-020 SHALL use these ecode values: INT 0x00, ADEF 0x08, ALE 0x09, SYS 0x0B, BRK 0x0C, INE 0x0D; esubcode 0 for all.
REQ-021 SHALL, on a normal accept, pulse wb_commit in the same cycle and stay in IDLE.
REQ-022 SHALL, on an exception, INT or ERTN accept, register ecode, esubcode, wb_pc, wb_vaddr and the kind (exc/ertn), then go to COMMIT.
REQ-023 SHALL not pulse wb_commit for an instruction that takes an INT; that instruction is not retired and ERA receives its PC.
REQ-024 SHALL, in COMMIT (one cycle), pulse csr_wb_ex (exception/INT) or csr_ertn_flush (ERTN), assert flush, then go to FLUSH.
REQ-025 SHALL drive csr_ecode, csr_esubcode, csr_pc and csr_vaddr from registers, valid in COMMIT, with csr_vaddr=wb_pc for ADEF.
REQ-026 SHALL hold flush=1 through FLUSH for exactly FLUSH_CYCLES cycles using a down-counter, then go to REDIRECT.
REQ-027 SHALL, in REDIRECT, assert flush and redirect_valid with redirect_pc = csr_eentry (exception) or csr_era (ERTN), sampled combinationally.
REQ-028 SHALL keep redirect_pc stable until redirect_ready, then return to IDLE on that same edge.
REQ-029 SHALL ignore wb_valid, wb_exc and has_int outside IDLE.
REQ-030 SHALL treat has_int with wb_valid=0 as no event; an interrupt is taken only together with an offered instruction.
REQ-031 SHALL handle ERTN together with any wb_exc bit set as the exception; csr_ertn_flush is not pulsed.

Reset
REQ-032 SHALL force state IDLE on reset, including mid-operation, and abandon any pending redirect.
REQ-033 SHALL reset all outputs and registered records to 0 except wb_accept, which is 1 in the cycle after reset is released.

Configuration
REQ-034 SHALL, with EXC_CTRL_INT_EN defined, honour has_int per REQ-019.
REQ-035 SHALL, without EXC_CTRL_INT_EN defined, keep the has_int port but ignore it, so INT is never taken.

Structure
REQ-036 SHALL place ecode/esubcode constants, wb_exc bit indices and the state encoding in shared package exc_pkg.
REQ-037 SHALL implement classification (REQ-019/020) in sub-module exc_prio_enc, purely combinational.

Verification
REQ-038 SHALL cover: wb_exc=5'b00100, pc=0x1c000100, eentry=0x1c008000 -> csr_wb_ex pulse with ecode 0x0B and csr_pc=0x1c000100, flush for 1+2 cycles, then redirect_pc=0x1c008000.
REQ-039 SHALL cover: wb_exc=5'b10001, vaddr=0x5 -> ecode 0x08, csr_vaddr=wb_pc.
REQ-040 SHALL cover: wb_ertn=1, era=0x1c000200 -> csr_ertn_flush pulse, no csr_wb_ex, redirect_pc=0x1c000200.
REQ-041 SHALL cover: has_int=1 with wb_exc=5'b00010 (with EXC_CTRL_INT_EN) -> ecode 0x00, no wb_commit; without the macro -> ecode 0x0D.
REQ-042 SHALL cover: redirect_ready held low for 5 cycles -> redirect_valid and redirect_pc stable, wb_accept=0, and a wb_valid in that window is not accepted.
REQ-043 SHALL cover: reset asserted in FLUSH -> next cycle IDLE, flush=0, redirect_valid=0, wb_accept=1 after release.
